// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   slice_w()            : bits handled by each pipeline slice
//   stage_ctl_t          : per-stage control fields (valid bit, registered carry)
//   sat_max() / sat_min(): signed max/min patterns for a given width. The result is
//                          MaxWidth bits wide; callers truncate it to their own width.
package pipelined_adder_pkg;

  localparam int unsigned MaxWidth = 1024;

  // Control portion of the per-stage payload. The operand and partial-sum fields depend
  // on WIDTH, so the top wraps this struct in a width-specific payload struct.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int unsigned slice_w(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_max(int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    for (int unsigned i = 0; i + 1 < width; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [MaxWidth-1:0] sat_min(int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    if (width > 0) v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Stream interface of the pipelined adder.
//   master: operand producer and result consumer (drives in_valid, a, b, cin, sub,
//           out_ready)
//   slave : the adder (drives in_ready, out_valid, sum, cout, ovf)
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder_add_slice.sv
// add_slice: combinational W-bit adder with carry in and carry out. One instance per
// pipeline stage.
//   i_a, i_b : slice operands (i_b already inverted for subtract)
//   i_cin    : carry from the previous slice
//   o_sum    : slice sum
//   o_cout   : carry into the next slice
module add_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  always_comb begin
    {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-propagating slices,
// with valid/ready handshaking on both sides.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; discards every in-flight transaction
//   bus : pipelined_adder_if slave modport (operands in, sum/cout/ovf out)
// Optional build macro PIPELINED_ADDER_SAT_EN: on signed overflow, sum saturates to
// signed max/min (chosen by a[MSB]). Without it, sum wraps modulo 2^WIDTH.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be in 1..WIDTH");
  end
  if (WIDTH % SW != 0 || SW * STAGES != WIDTH) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be divisible by STAGES");
  end

  // Operands of unprocessed slices ride along. b holds the sub-resolved operand.
  // Finished sum slices are carried forward in sum.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } payload_t;

  payload_t r_stage [STAGES];
  payload_t w_nxt   [STAGES];
  payload_t w_last;
  logic     w_advance;
  logic     w_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t         w_in;
    logic [SW-1:0]    w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_merged;

    if (k == 0) begin : g_first
      always_comb begin
        w_in           = '0;
        w_in.ctl.valid = bus.in_valid;
        w_in.ctl.carry = bus.cin ^ bus.sub;
        w_in.a         = bus.a;
        w_in.b         = bus.sub ? ~bus.b : bus.b;
      end
    end else begin : g_next
      assign w_in = r_stage[k-1];
    end

    add_slice #(
      .W (SW)
    ) u_slice (
      .i_a    (w_in.a[k*SW +: SW]),
      .i_b    (w_in.b[k*SW +: SW]),
      .i_cin  (w_in.ctl.carry),
      .o_sum  (w_slice_sum),
      .o_cout (w_slice_cout)
    );

    always_comb begin
      w_sum_merged              = w_in.sum;
      w_sum_merged[k*SW +: SW]  = w_slice_sum;
    end

    assign w_nxt[k] = {w_in.ctl.valid, w_slice_cout, w_in.a, w_in.b, w_sum_merged};
  end

  // The whole pipe moves in lockstep, so bubbles are never squeezed out. Data fields
  // load only with a valid transaction so outputs keep their last value on bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) r_stage[k] <= '0;
    end else if (w_advance) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (w_nxt[k].ctl.valid) r_stage[k] <= w_nxt[k];
        else                    r_stage[k].ctl.valid <= 1'b0;
      end
    end
  end

  assign w_last    = r_stage[STAGES-1];
  assign w_advance = !w_last.ctl.valid || bus.out_ready;

  assign bus.in_ready  = w_advance && !rst;
  assign bus.out_valid = w_last.ctl.valid;
  assign bus.cout      = w_last.ctl.carry;

  // The last stage still holds the MSBs of a and b_eff, so overflow is derived here.
  assign w_ovf   = (w_last.a[WIDTH-1] == w_last.b[WIDTH-1]) &&
                   (w_last.sum[WIDTH-1] != w_last.a[WIDTH-1]);
  assign bus.ovf = w_ovf;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));

  if (WIDTH > MaxWidth) begin : g_bad_sat_width
    $error("pipelined_adder: WIDTH exceeds saturation helper range");
  end

  assign bus.sum = w_ovf ? (w_last.a[WIDTH-1] ? SatMin : SatMax) : w_last.sum;
`else
  assign bus.sum = w_last.sum;
`endif

endmodule
